// File: rtl/signed_mul_seq_if.sv
// Handshake bundle for signed_mul_seq: start/operands in, busy/done/product out.
// The ovf signal exists only when SIGNED_MUL_OVF_EN is defined.
interface signed_mul_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
`ifdef SIGNED_MUL_OVF_EN
    logic        ovf;
`endif

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
`ifdef SIGNED_MUL_OVF_EN
        ,
        input  ovf
`endif
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
`ifdef SIGNED_MUL_OVF_EN
        ,
        output ovf
`endif
    );
endinterface

// File: rtl/signed_mul_seq.sv
// Sequential 32x32 signed multiplier: sign-magnitude shift-add, 32 iterations, low-word result.
// Define SIGNED_MUL_OVF_EN to add the ovf flag (64-bit product does not fit in 32 bits).
module signed_mul_seq (
    input  logic             clk,
    input  logic             rst,
    signed_mul_seq_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StNegin, StMul, StNegout, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sign_q, sign_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] product_q, product_d;
    logic [31:0] add_term;
    logic [32:0] sum;
    logic [63:0] result;
`ifdef SIGNED_MUL_OVF_EN
    logic        ovf_q, ovf_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
`ifdef SIGNED_MUL_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            product_q <= product_d;
`ifdef SIGNED_MUL_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        product_d = product_q;
`ifdef SIGNED_MUL_OVF_EN
        ovf_d     = ovf_q;
`endif
        // Multiplier magnitude sits in acc[31:0] and drains out as the sum shifts in.
        add_term = acc_q[0] ? a_q : 32'd0;
        sum      = {1'b0, acc_q[63:32]} + {1'b0, add_term};
        // Two's complement of zero is zero, so no special case is needed.
        result   = sign_q ? (~acc_q + 64'd1) : acc_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sign_d  = bus.a[31] ^ bus.b[31];
                    state_d = StNegin;
                end
            end
            StNegin: begin
                a_d     = a_q[31] ? (~a_q + 32'd1) : a_q;
                acc_d   = {32'd0, (b_q[31] ? (~b_q + 32'd1) : b_q)};
                cnt_d   = 6'd0;
                state_d = StMul;
            end
            StMul: begin
                acc_d = {sum, acc_q[31:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = StNegout;
                end
            end
            StNegout: begin
                acc_d     = result;
                product_d = result[31:0];
`ifdef SIGNED_MUL_OVF_EN
                ovf_d     = (|result[63:31]) && !(&result[63:31]);
`endif
                state_d   = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StDone);
    assign bus.product = product_q;
`ifdef SIGNED_MUL_OVF_EN
    assign bus.ovf     = ovf_q;
`endif

endmodule

// File: doc/signed_mul_seq.md
SIGNED_MUL_SEQ -- requirements
Module: signed_mul_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, declared first as: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-low reset.
REQ-002 Port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-003 Port: a  input  32  signed two's-complement multiplicand; sampled with start.
REQ-004 Port: b  input  32  signed two's-complement multiplier; sampled with start.
REQ-005 Port: busy  output  1  high in every state except IDLE.
REQ-006 Port: done  output  1  one-cycle pulse; product valid.
REQ-007 Port: product  output  32  low 32 bits of signed a*b; held until the next accepted start.
REQ-008 Port (present only with SIGNED_MUL_OVF_EN): ovf  output  1  signed 64-bit product does not fit in 32 bits; valid with done, held with product.

Function
REQ-009 The FSM SHALL have the states IDLE, NEGIN, MUL, NEGOUT and DONE, with the transitions: IDLE->NEGIN on start=1; NEGIN->MUL; MUL->NEGOUT after 32 iterations; NEGOUT->DONE; DONE->IDLE.
REQ-010 The block SHALL latch a, b and the result sign (a[31] XOR b[31]) at the rising edge where start=1 in IDLE.
REQ-011 The NEGIN state SHALL replace each negative operand with its magnitude (~x+1) as a 32-bit unsigned value; 0x80000000 SHALL give magnitude 0x80000000.
REQ-012 The MUL state SHALL perform one unsigned shift-add iteration per cycle into a 64-bit accumulator, for exactly 32 cycles, using a 6-bit iteration counter that is cleared in NEGIN.
REQ-013 The NEGOUT state SHALL two's-complement the 64-bit accumulator when the result sign is 1; a zero magnitude SHALL stay zero.
REQ-014 In DONE, product SHALL be accumulator[31:0] and done SHALL be 1 for exactly one cycle.
REQ-015 Latency: when start is sampled at edge N, done SHALL be high in the cycle after edge N+34, and busy SHALL be high from edge N through edge N+35.
REQ-016 The block SHALL ignore start while busy=1; a start held high through DONE SHALL be accepted on the first cycle back in IDLE.
REQ-017 The block SHALL NOT sample changes on a or b after the accepting edge.
REQ-018 product SHALL NOT change outside the edge that enters DONE.

Reset
REQ-019 When rst=0, the block SHALL immediately force: state=IDLE, busy=0, done=0, product=0, ovf=0, counter=0 and accumulator=0.
REQ-020 A reset asserted mid-operation SHALL abort the operation with no done pulse, and the first start after reset release SHALL be processed normally.

Configuration
REQ-021 With SIGNED_MUL_OVF_EN defined, the ovf port and its logic SHALL exist, and ovf SHALL be 1 when accumulator[63:31] after NEGOUT is neither all-0 nor all-1.
REQ-022 With SIGNED_MUL_OVF_EN undefined, the block SHALL have no ovf port and SHALL have identical timing and product behaviour.

Verification
REQ-023 Scenario: a=7, b=-3 (0xFFFFFFFD) -> product=0xFFFFFFEB (-21), ovf=0, and done exactly 35 cycles after the start edge.
REQ-024 Scenario: a=0x80000000, b=1 -> product=0x80000000, ovf=0; a=0x80000000, b=-1 -> product=0x80000000, ovf=1.
REQ-025 Scenario: a=0, b=-5 -> product=0x00000000, ovf=0 (negative-sign zero case).
REQ-026 Scenario: a=0x00010000, b=0x00010000 -> product=0x00000000, ovf=1.
REQ-027 Scenario: a second start pulsed at cycle 10 of the MUL state -> ignored; one done pulse only; product from the first operands.
REQ-028 Scenario: rst=0 at cycle 20 of the MUL state, then released -> busy=0, done=0, product=0 immediately; then start with a=-2, b=-2 -> product=4 after 35 cycles.
